// File: rtl/des_pkg.sv
// DES constant tables, key-rotation schedules and the bit-level helpers shared by the core and the round.
// Table entries use FIPS 46 numbering, so bit 1 is the MSB of each vector.
package des_pkg;

  typedef logic [63:0] block_t;
  typedef enum logic {IDLE, ROUND} state_t;

  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TBL [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_TBL [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Each box is stored row-major: index = row*16 + col.
  localparam int SBOX_TBL [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

  localparam int ENC_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int DEC_SHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  function automatic block_t ip_perm(input block_t x);
    block_t y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_TBL[i]];
    return y;
  endfunction

  function automatic block_t fp_perm(input block_t x);
    block_t y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_TBL[i]];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input block_t x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_TBL[i]];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_TBL[i]];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[32-E_TBL[i]];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[31-i] = x[32-P_TBL[i]];
    return y;
  endfunction

  // Outer bits of each 6-bit group pick the row, inner four pick the column.
  function automatic logic [31:0] sbox_subst(input logic [47:0] x);
    logic [31:0] y;
    logic [5:0]  b;
    y = '0;
    for (int j = 0; j < 8; j++) begin
      b = x[47-6*j -: 6];
      y[31-4*j -: 4] = SBOX_TBL[j][{b[5], b[0], b[4:1]}][3:0];
    end
    return y;
  endfunction

  function automatic logic [27:0] ks_rotate(input logic [27:0] v, input logic enc, input logic [3:0] rnd);
    if (enc)
      return (ENC_SHIFT[rnd] == 2) ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
    case (DEC_SHIFT[rnd])
      1:       return {v[0], v[27:1]};
      2:       return {v[1:0], v[27:2]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/des_round.sv
// One combinational DES Feistel round: expansion, key mix, S-boxes and P permutation.
module des_round
  import des_pkg::*;
(
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] l_next,
  output logic [31:0] r_next
);

  assign l_next = r;
  assign r_next = l ^ p_perm(sbox_subst(e_expand(r) ^ k));

endmodule

// File: rtl/des_core.sv
// Iterative DES engine: one Feistel round per clock, key schedule rotated in place.
//   state | meaning
//   IDLE  | waiting for start; ciphertext holds the last result
//   ROUND | executing rounds 1..16, one per clock
module des_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        encrypt,
  input  logic [63:0] key,
  input  logic [63:0] plaintext,
  output logic [63:0] ciphertext,
  output logic        busy,
  output logic        done
);

  state_t      state, next_state;
  logic [3:0]  round_cnt;
  logic [31:0] l_reg, r_reg, l_next, r_next;
  logic [27:0] c_reg, d_reg, c_rot, d_rot;
  logic [47:0] subkey;
  logic        enc_reg;
  logic        last_round;

  assign busy       = (state == ROUND);
  assign last_round = (round_cnt == 4'd15);

  // Decrypt walks the schedule backwards by rotating right, so K16 comes out first.
  assign c_rot  = ks_rotate(c_reg, enc_reg, round_cnt);
  assign d_rot  = ks_rotate(d_reg, enc_reg, round_cnt);
  assign subkey = pc2_perm({c_rot, d_rot});

  des_round u_round (
    .l      (l_reg),
    .r      (r_reg),
    .k      (subkey),
    .l_next (l_next),
    .r_next (r_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ROUND;
      ROUND:   if (last_round) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_reg      <= '0;
      r_reg      <= '0;
      c_reg      <= '0;
      d_reg      <= '0;
      enc_reg    <= 1'b0;
      round_cnt  <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          {l_reg, r_reg} <= ip_perm(plaintext);
          {c_reg, d_reg} <= pc1_perm(key);
          enc_reg        <= encrypt;
          round_cnt      <= '0;
        end
      end else begin
        l_reg     <= l_next;
        r_reg     <= r_next;
        c_reg     <= c_rot;
        d_reg     <= d_rot;
        round_cnt <= round_cnt + 4'd1;
        if (last_round) begin
          ciphertext <= fp_perm({r_next, l_next});
          done       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_core.sv
// Self-checking bench for des_core: known-answer vectors, random blocks against a
// whole-block DES model, round trips, back-to-back starts, ignored starts and reset abort.
module tb_des_core;
  import des_pkg::*;

  localparam int ROT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        encrypt;
  logic [63:0] key;
  logic [63:0] plaintext;
  logic [63:0] ciphertext;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  des_core dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .encrypt    (encrypt),
    .key        (key),
    .plaintext  (plaintext),
    .ciphertext (ciphertext),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // Reference: full subkey list up front, decrypt by using it in reverse, FP taken as IP inverse.
  function automatic logic [63:0] model_des(input logic [63:0] k, input logic [63:0] blk, input bit enc);
    logic [55:0] cd;
    logic [47:0] ks [16];
    logic [47:0] x;
    logic [63:0] ipb, pre, res;
    logic [31:0] l, r, f, pf, nl;
    logic [27:0] c, d;
    logic [5:0]  b;
    int          row, col;
    for (int i = 0; i < 56; i++) cd[55-i] = k[64-PC1_TBL[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int n = 0; n < ROT[rd]; n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[rd][47-i] = cd[56-PC2_TBL[i]];
    end
    for (int i = 0; i < 64; i++) ipb[63-i] = blk[64-IP_TBL[i]];
    l = ipb[63:32];
    r = ipb[31:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TBL[i]];
      x = x ^ (enc ? ks[rd] : ks[15-rd]);
      for (int j = 0; j < 8; j++) begin
        b   = x[47-6*j -: 6];
        row = int'({b[5], b[0]});
        col = int'(b[4:1]);
        f[31-4*j -: 4] = 4'(SBOX_TBL[j][16*row + col]);
      end
      for (int i = 0; i < 32; i++) pf[31-i] = f[32-P_TBL[i]];
      nl = l ^ pf;
      l  = r;
      r  = nl;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) res[64-IP_TBL[i]] = pre[63-i];
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called away from a rising edge with busy=0; returns 1 time unit after the start edge.
  task automatic start_op(input logic [63:0] k, input logic [63:0] blk, input bit enc);
    key       = k;
    plaintext = blk;
    encrypt   = enc;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    key       = {$urandom, $urandom};
    plaintext = {$urandom, $urandom};
    encrypt   = 1'($urandom_range(0, 1));
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string tag, input logic [63:0] exp, input int elapsed);
    int cyc;
    cyc = elapsed;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd16);
    check({tag, "_result"}, ciphertext, exp);
    check({tag, "_busy_clear"}, 64'(busy), 64'd0);
  endtask

  task automatic idle_check(input string tag, input logic [63:0] held);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_hold"}, ciphertext, held);
  endtask

  initial begin
    logic [63:0] k, b, exp, got;
    bit          e;
    int          done_cnt;

    rst_n = 1'b0;
    start = 1'b0;
    encrypt = 1'b0;
    key = '0;
    plaintext = '0;
    #12;
    check("reset_ct", ciphertext, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    start_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1);
    wait_done("kat_enc", 64'h85E813540F0AB405, 0);
    start_op(64'h133457799BBCDFF1, 64'h85E813540F0AB405, 1'b0);
    wait_done("kat_dec_b2b", 64'h0123456789ABCDEF, 0);
    idle_check("kat_dec", 64'h0123456789ABCDEF);

    start_op(64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b1);
    wait_done("kat_8787", 64'h0000000000000000, 0);
    idle_check("kat_8787", 64'h0000000000000000);
    start_op(64'h0000000000000000, 64'h0000000000000000, 1'b1);
    wait_done("kat_zero", 64'h8CA64DE9C1B123A7, 0);
    idle_check("kat_zero", 64'h8CA64DE9C1B123A7);

    for (int n = 0; n < 8; n++) begin
      k   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      e   = 1'($urandom_range(0, 1));
      exp = model_des(k, b, e);
      start_op(k, b, e);
      wait_done("rand", exp, 0);
      got = ciphertext;
      start_op(k, got, !e);
      wait_done("rand_roundtrip", b, 0);
      idle_check("rand", b);
    end

    k   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    exp = model_des(k, b, 1'b1);
    start_op(k, b, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    key = {$urandom, $urandom};
    plaintext = {$urandom, $urandom};
    encrypt = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ignored_start_busy", 64'(busy), 64'd1);
    wait_done("ignored_start", exp, 5);
    idle_check("ignored_start", exp);

    start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    plaintext = {$urandom, $urandom};
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_ct", ciphertext, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    done_cnt = 0;
    repeat (24) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    start_op(64'h133457799BBCDFF1, 64'h0123456789ABCDEF, 1'b1);
    wait_done("post_reset", 64'h85E813540F0AB405, 0);
    idle_check("post_reset", 64'h85E813540F0AB405);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
